// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : Shared state encoding and width limits for the bit-serial
//            arithmetic blocks (adder, future subtractor).
// Revision : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : One-bit combinational full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign sum    = w_half ^ cin;
    assign cout   = (a & b) | (cin & w_half);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial adder, LSB first, one bit per clock through a single
//            full-adder cell with a registered carry; valid/ready on both ends.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH out of range 2..32");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic [c_CW-1:0]  r_cnt;
    logic             r_carry;
    logic             w_sum_bit;
    logic             w_carry_out;

    full_adder u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .sum  (w_sum_bit),
        .cout (w_carry_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_s_sr  <= {w_sum_bit, r_s_sr[WIDTH-1:1]};
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_carry <= w_carry_out;
                    // Hold the counter on the final bit so it never wraps.
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state == c_RUN);
    assign out_valid = (r_state == c_DONE);
    assign sum       = r_s_sr;
    assign cout      = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder at WIDTH=8 (directed) and
//            WIDTH=4 (exhaustive operand sweep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results are compared on the negedge before the accepting clock edge.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) check("w8_unexpected_result", 32'd1, 32'd0);
            else check("w8_result", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
        end
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) check("w4_unexpected_result", 32'd1, 32'd0);
            else check("w4_result", {27'd0, cout4, sum4}, {27'd0, q4.pop_front()});
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input bit push);
        int n = 0;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready8) check("w8_in_ready_timeout", 32'd0, 32'd1);
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n = 0;
        logic [4:0] e;
        while (!in_ready4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready4) check("w4_in_ready_timeout", 32'd0, 32'd1);
        e = {1'b0, a} + {1'b0, b} + {4'd0, c};
        a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
        q4.push_back(e);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_idle8(input string tag);
        int n = 0;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready8) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", {31'd0, in_ready8}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);

        // Basic add with latency and single-cycle valid pulse.
        out_ready8 = 1'b1;
        send8(8'h3C, 8'h5A, 1'b0, 9'h096, 1'b1);
        check("t1_busy", {31'd0, busy8}, 32'd1);
        check("t1_in_ready_run", {31'd0, in_ready8}, 32'd0);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("t1_latency", lat, 32'd8);
        check("t1_busy_done", {31'd0, busy8}, 32'd0);
        @(posedge clk); #1;
        check("t1_pulse", {31'd0, out_valid8}, 32'd0);
        check("t1_in_ready_after", {31'd0, in_ready8}, 32'd1);

        // Carry propagation corners.
        send8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        send8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        wait_idle8("t2_idle_timeout");

        // Backpressure: result held while the consumer stalls.
        out_ready8 = 1'b0;
        send8(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_sum_held", {24'd0, sum8}, 32'h46);
            check("t3_valid_held", {31'd0, out_valid8}, 32'd1);
            check("t3_in_ready_low", {31'd0, in_ready8}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("t3_in_ready_after_hs", {31'd0, in_ready8}, 32'd1);
        check("t3_valid_after_hs", {31'd0, out_valid8}, 32'd0);

        // Inputs changing during RUN must not disturb the latched operands.
        send8(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
        for (int i = 0; i < 6; i++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        wait_idle8("t4_idle_timeout");

        // Reset mid-run discards the operation.
        send8(8'h77, 8'h11, 1'b0, 9'h000, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_in_ready", {31'd0, in_ready8}, 32'd1);
        check("t5_out_valid", {31'd0, out_valid8}, 32'd0);
        check("t5_busy", {31'd0, busy8}, 32'd0);
        check("t5_sum", {24'd0, sum8}, 32'd0);
        check("t5_cout", {31'd0, cout8}, 32'd0);
        send8(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
        wait_idle8("t5_idle_timeout");

        // Exhaustive sweep of all operand/carry combinations at WIDTH=4.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            send4(v[3:0], v[7:4], v[8]);
        end

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("q8_drained", q8.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
